bit_stuffer: RTL and testbench

Serializing bit-stuffing transmitter that feeds the serial stuffed-zero/flag detector stage. It accepts parallel bytes over a valid/ready handshake, shifts them out LSB-first at one bit per clock, and inserts a 0 after every run of STUFF_RUN consecutive 1 data bits. Its serial output is the detector's input stream.

---
 rtl/bit_stuffer_if.sv | 22 ++
 rtl/bit_stuffer.sv | 203 ++++++++++++++++++++
 tb/tb_bit_stuffer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_stuffer_if.sv
// Handshake and serial-stream bundle for bit_stuffer.
// The master drives words in and observes the stream; the slave is the stuffer itself.
interface bit_stuffer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              out;
    logic              out_valid;
    logic              stuffed;

    modport master (
        output din, din_valid,
        input  din_ready, out, out_valid, stuffed
    );

    modport slave (
        input  din, din_valid,
        output din_ready, out, out_valid, stuffed
    );
endinterface

// File: rtl/bit_stuffer.sv
// LSB-first serializer that inserts a 0 after STUFF_RUN consecutive 1 data bits.
// Define BIT_STUFFER_FLAG_EN to wrap every burst in 0x7E open/close flags.
module bit_stuffer #(
    parameter int DATA_W    = 8,
    parameter int STUFF_RUN = 5
) (
    input  logic         clk,
    input  logic         rst,
    bit_stuffer_if.slave bus
);
    localparam int CW = $clog2(STUFF_RUN + 1);
    localparam int IW = $clog2(DATA_W + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SHIFT = 3'd1;
    localparam logic [2:0] STUFF = 3'd2;
`ifdef BIT_STUFFER_FLAG_EN
    localparam logic [2:0] FLAG_OPEN   = 3'd3;
    localparam logic [2:0] FLAG_CLOSE  = 3'd4;
    localparam logic [2:0] START_STATE = FLAG_OPEN;
    localparam logic [2:0] END_STATE   = FLAG_CLOSE;
    localparam logic [7:0] FLAG        = 8'h7E;
`else
    localparam logic [2:0] START_STATE = SHIFT;
    localparam logic [2:0] END_STATE   = IDLE;
`endif

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] RUN_LAST = CW'(STUFF_RUN - 1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
    localparam logic [IW-1:0] IDX_DONE = IW'(DATA_W);

    logic [2:0]        state_r, state_s;
    logic [DATA_W-1:0] sh_r, sh_s;
    logic [IW-1:0]     bit_idx_r, bit_idx_s;
    logic [CW-1:0]     ones_cnt_r, ones_cnt_s;
    logic              out_r, out_s;
    logic              out_valid_r, out_valid_s;
    logic              stuffed_r, stuffed_s;
    logic              stuff_due_s;
    logic              word_end_s;
    logic              ready_s;
`ifdef BIT_STUFFER_FLAG_EN
    logic [2:0]        flag_idx_r, flag_idx_s;
`endif

    // Decode word boundary and handshake readiness from the registered state
    always_comb begin
        stuff_due_s = 1'b0;
        word_end_s  = 1'b0;
        ready_s     = 1'b0;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
            end
            SHIFT: begin
                stuff_due_s = sh_r[0] && (ones_cnt_r == RUN_LAST);
                word_end_s  = (bit_idx_r == IDX_LAST) && !stuff_due_s;
                ready_s     = word_end_s;
            end
            STUFF: begin
                word_end_s = (bit_idx_r == IDX_DONE);
                ready_s    = word_end_s;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Ready is forced low while reset is held so nothing is accepted mid-reset
    assign bus.din_ready = ready_s & rst;

    // Next-state and next-output computation
    always_comb begin
        state_s     = state_r;
        sh_s        = sh_r;
        bit_idx_s   = bit_idx_r;
        ones_cnt_s  = ones_cnt_r;
        out_s       = 1'b1;
        out_valid_s = 1'b0;
        stuffed_s   = 1'b0;
`ifdef BIT_STUFFER_FLAG_EN
        flag_idx_s  = flag_idx_r;
`endif
        case (state_r)
            IDLE: begin
                ones_cnt_s = CNT_ZERO;
                if (bus.din_valid) begin
                    sh_s      = bus.din;
                    bit_idx_s = IDX_ZERO;
                    state_s   = START_STATE;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                out_s       = sh_r[0];
                out_valid_s = 1'b1;
                sh_s        = {1'b0, sh_r[DATA_W-1:1]};
                bit_idx_s   = bit_idx_r + IDX_ONE;
                ones_cnt_s  = sh_r[0] ? (ones_cnt_r + CNT_ONE) : CNT_ZERO;
                if (stuff_due_s) begin
                    ones_cnt_s = CNT_ZERO;
                    state_s    = STUFF;
                end else if (word_end_s) begin
                    // Run length carries into the next word of a burst
                    if (bus.din_valid) begin
                        sh_s      = bus.din;
                        bit_idx_s = IDX_ZERO;
                        state_s   = SHIFT;
                    end else begin
                        ones_cnt_s = CNT_ZERO;
                        state_s    = END_STATE;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            STUFF: begin
                out_s       = 1'b0;
                out_valid_s = 1'b1;
                stuffed_s   = 1'b1;
                ones_cnt_s  = CNT_ZERO;
                if (word_end_s) begin
                    if (bus.din_valid) begin
                        sh_s      = bus.din;
                        bit_idx_s = IDX_ZERO;
                        state_s   = SHIFT;
                    end else begin
                        state_s = END_STATE;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
`ifdef BIT_STUFFER_FLAG_EN
            FLAG_OPEN: begin
                out_s       = FLAG[flag_idx_r];
                out_valid_s = 1'b1;
                ones_cnt_s  = CNT_ZERO;
                flag_idx_s  = flag_idx_r + 3'd1;
                if (flag_idx_r == 3'd7) begin
                    state_s = SHIFT;
                end else begin
                    state_s = FLAG_OPEN;
                end
            end
            FLAG_CLOSE: begin
                out_s       = FLAG[flag_idx_r];
                out_valid_s = 1'b1;
                ones_cnt_s  = CNT_ZERO;
                flag_idx_s  = flag_idx_r + 3'd1;
                if (flag_idx_r == 3'd7) begin
                    state_s = IDLE;
                end else begin
                    state_s = FLAG_CLOSE;
                end
            end
`endif
            default: begin
                state_s    = IDLE;
                ones_cnt_s = CNT_ZERO;
                bit_idx_s  = IDX_ZERO;
            end
        endcase
    end

    // State and registered serial outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            sh_r        <= {DATA_W{1'b0}};
            bit_idx_r   <= IDX_ZERO;
            ones_cnt_r  <= CNT_ZERO;
            out_r       <= 1'b1;
            out_valid_r <= 1'b0;
            stuffed_r   <= 1'b0;
`ifdef BIT_STUFFER_FLAG_EN
            flag_idx_r  <= 3'd0;
`endif
        end else begin
            state_r     <= state_s;
            sh_r        <= sh_s;
            bit_idx_r   <= bit_idx_s;
            ones_cnt_r  <= ones_cnt_s;
            out_r       <= out_s;
            out_valid_r <= out_valid_s;
            stuffed_r   <= stuffed_s;
`ifdef BIT_STUFFER_FLAG_EN
            flag_idx_r  <= flag_idx_s;
`endif
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.stuffed   = stuffed_r;

endmodule

// File: tb/tb_bit_stuffer.sv
// Self-checking bench for bit_stuffer: directed bursts plus randomized bursts
// compared cycle by cycle against a stream-level stuffing model.
module tb_bit_stuffer;
    localparam int DATA_W    = 8;
    localparam int STUFF_RUN = 5;
`ifdef BIT_STUFFER_FLAG_EN
    localparam int FLAG_LEN  = 8;
`else
    localparam int FLAG_LEN  = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    bit_stuffer_if #(.DATA_W(DATA_W)) bus ();

    bit_stuffer #(
        .DATA_W   (DATA_W),
        .STUFF_RUN(STUFF_RUN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [DATA_W-1:0] burst_q[$];
    logic              exp_bit[$];
    logic              exp_stf[$];
    logic              exp_end[$];

    task automatic push_elem(input logic b, input logic s);
        exp_bit.push_back(b);
        exp_stf.push_back(s);
        exp_end.push_back(1'b0);
    endtask

    // Expected frame: optional flag, stuffed data of the whole burst, optional flag
    task automatic build_model();
        int run;
        logic b;
        logic [7:0] flag;
        flag = 8'h7E;
        exp_bit.delete();
        exp_stf.delete();
        exp_end.delete();
`ifdef BIT_STUFFER_FLAG_EN
        for (int i = 0; i < 8; i++) push_elem(flag[i], 1'b0);
`endif
        run = 0;
        foreach (burst_q[w]) begin
            for (int i = 0; i < DATA_W; i++) begin
                b = burst_q[w][i];
                push_elem(b, 1'b0);
                run = b ? run + 1 : 0;
                if (run == STUFF_RUN) begin
                    push_elem(1'b0, 1'b1);
                    run = 0;
                end
            end
            exp_end[exp_end.size() - 1] = 1'b1;
        end
`ifdef BIT_STUFFER_FLAG_EN
        for (int i = 0; i < 8; i++) push_elem(flag[i], 1'b0);
`endif
        if (flag != 8'h7E) $display("model flag corrupted");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive burst_q back-to-back from IDLE and check every cycle until idle again
    task automatic run_burst(input string name);
        int widx, n, len, stf_seen, stf_exp;
        logic rdy, ev, eo, es, er;
        build_model();
        n   = burst_q.size();
        len = exp_bit.size();
        stf_exp = 0;
        foreach (exp_stf[i]) if (exp_stf[i]) stf_exp++;
        stf_seen = 0;
        widx = 0;
        total++;
        if (bus.din_ready !== 1'b1) begin
            $display("FAIL %s idle_ready: got %b want 1", name, bus.din_ready);
        end else begin
            passed++;
        end
        bus.din       = burst_q[0];
        bus.din_valid = 1'b1;
        for (int k = -1; k <= len; k++) begin
            rdy = bus.din_ready;
            @(posedge clk);
            #1;
            if (rdy && bus.din_valid) begin
                widx++;
                if (widx < n) begin
                    bus.din = burst_q[widx];
                end else begin
                    bus.din_valid = 1'b0;
                    bus.din       = DATA_W'($urandom);
                end
            end
            if (k >= 0 && k < len) begin
                ev = 1'b1; eo = exp_bit[k]; es = exp_stf[k];
            end else begin
                ev = 1'b0; eo = 1'b1; es = 1'b0;
            end
            er = (k + 1 < len) ? exp_end[k + 1] : 1'b1;
            total++;
            if ({bus.out_valid, bus.out, bus.stuffed} !== {ev, eo, es}) begin
                $display("FAIL %s stream k=%0d: got valid/out/stuffed=%b%b%b want %b%b%b",
                         name, k, bus.out_valid, bus.out, bus.stuffed, ev, eo, es);
            end else begin
                passed++;
            end
            total++;
            if (bus.din_ready !== er) begin
                $display("FAIL %s din_ready k=%0d: got %b want %b", name, k, bus.din_ready, er);
            end else begin
                passed++;
            end
            if (bus.stuffed === 1'b1) stf_seen++;
        end
        total++;
        if (stf_seen != stf_exp || widx != n) begin
            $display("FAIL %s stuff_count: got %0d stuffs %0d words want %0d stuffs %0d words",
                     name, stf_seen, widx, stf_exp, n);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        bus.din       = '0;
        bus.din_valid = 1'b0;
        rst           = 1'b0;
        #23;
        total++;
        if ({bus.out, bus.out_valid, bus.stuffed, bus.din_ready} !== 4'b1000) begin
            $display("FAIL reset_values: got out/valid/stuffed/ready=%b%b%b%b want 1000",
                     bus.out, bus.out_valid, bus.stuffed, bus.din_ready);
        end else begin
            passed++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({bus.out, bus.out_valid, bus.din_ready} !== 3'b101) begin
            $display("FAIL reset_release: got out/valid/ready=%b%b%b want 101",
                     bus.out, bus.out_valid, bus.din_ready);
        end else begin
            passed++;
        end
    endtask

    task automatic test_single_ff();
        burst_q = '{8'hFF};
        run_burst("single_ff");
    endtask

    task automatic test_single_3e();
        burst_q = '{8'h3E};
        run_burst("single_3e");
    endtask

    task automatic test_back_to_back();
        burst_q = '{8'hF8, 8'h07};
        run_burst("b2b_f8_07");
        idle_cycles(1);
        burst_q = '{8'hFF, 8'hFF};
        run_burst("b2b_ff_ff");
        idle_cycles(2);
    endtask

    task automatic test_reset_midword();
        bus.din       = 8'hFF;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        idle_cycles(FLAG_LEN + 4);
        total++;
        if ({bus.out_valid, bus.out} !== 2'b11) begin
            $display("FAIL midword_pre: got valid/out=%b%b want 11", bus.out_valid, bus.out);
        end else begin
            passed++;
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({bus.out, bus.out_valid, bus.stuffed, bus.din_ready} !== 4'b1000) begin
            $display("FAIL midword_abort: got out/valid/stuffed/ready=%b%b%b%b want 1000",
                     bus.out, bus.out_valid, bus.stuffed, bus.din_ready);
        end else begin
            passed++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.din_ready !== 1'b1) begin
            $display("FAIL midword_release: got ready %b want 1", bus.din_ready);
        end else begin
            passed++;
        end
        @(posedge clk);
        #1;
        burst_q = '{8'h00};
        run_burst("after_reset_00");
    endtask

    task automatic test_random();
        int n;
        logic [DATA_W-1:0] w;
        for (int t = 0; t < 30; t++) begin
            burst_q.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                w = DATA_W'($urandom);
                if ($urandom_range(0, 2) == 0) w = w | 8'hF9;
                burst_q.push_back(w);
            end
            run_burst($sformatf("random_%0d", t));
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_single_ff();
        test_single_3e();
        test_back_to_back();
        test_reset_midword();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
